// File: rtl/bias_arbiter.sv
// Shares one bias evaluation unit (Y = A | (B & C)) among N_REQ valid/ready requesters.
// Define BIAS_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index always wins.
module bias_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [3*N_REQ-1:0]   req_abc,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_y,
  input  logic                 rsp_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] cand;
  logic            win_found;
  logic            grant;
  logic [2:0]      abc_sel;
  logic [2:0]      abc_q;
  logic [ID_W-1:0] id_q;

  // Search upward from the pointer, wrapping at N_REQ; the first valid requester wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant     = (state == IDLE) && !rst && win_found;
  assign req_ready = grant ? (N_REQ'(1) << win_idx) : '0;
  assign busy      = (state != IDLE);

  // Operand mux uses constant slice bases so only the winner's field is ever looked at.
  always_comb begin
    abc_sel = 3'b000;
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == win_idx) begin
        abc_sel = req_abc[3*k +: 3];
      end
    end
  end

`ifdef BIAS_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = EVAL;
      EVAL:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response registers hold steady through backpressure until the handshake edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      abc_q     <= 3'b000;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        abc_q <= abc_sel;
        id_q  <= win_idx;
      end
      if (state == EVAL) begin
        rsp_y     <= abc_q[2] | (abc_q[1] & abc_q[0]);
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bias_arbiter.sv
// Self-checking bench for bias_arbiter: a cycle model predicts grants and pushes expected
// results into a scoreboard that an independent monitor drains on the response port.
module tb_bias_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [3*N-1:0]  req_abc = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic            rsp_y;
  logic            rsp_ready = 1'b0;
  logic            busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    int y;
  } exp_t;
  exp_t sb[$];

  // Reference model: whether a job is outstanding, edges since acceptance, next-search start.
  bit         pending = 1'b0;
  int         age = 0;
  int         ptr = 0;
  logic [2:0] cur_abc [N];

  bias_arbiter #(.N_REQ(N), .ID_W(ID_W)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_abc(req_abc),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_y(rsp_y),
    .rsp_ready(rsp_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int pickWinner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput();
    int           w;
    logic [N-1:0] exp_ready;
    w = pickWinner(req_valid);
    exp_ready = '0;
    if (!rst && !pending && w >= 0) exp_ready[w] = 1'b1;
    checkVal("req_ready", int'(req_ready), int'(exp_ready));
    checkVal("busy", int'(busy), int'(pending));
    checkVal("rsp_valid", int'(rsp_valid), int'(pending && age >= 1));
  endtask

  // Drives one cycle of inputs, checks outputs, then advances the model across the coming edge.
  task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic rr);
    logic [3*N-1:0] abc;
    int             w;
    exp_t           e;
    @(negedge clk);
    for (int i = 0; i < N; i++) abc[3*i +: 3] = cur_abc[i];
    rst       = r;
    req_valid = v;
    req_abc   = abc;
    rsp_ready = rr;
    #1;
    checkOutput();
    w = pickWinner(v);
    if (r) begin
      sb.delete();
      pending = 1'b0;
      age     = 0;
      ptr     = 0;
    end else if (!pending) begin
      if (w >= 0) begin
        e.id = w;
        e.y  = int'(cur_abc[w][2] | (cur_abc[w][1] & cur_abc[w][0]));
        sb.push_back(e);
        pending = 1'b1;
        age     = 0;
`ifdef BIAS_ARB_ROUND_ROBIN_EN
        ptr = (w + 1) % N;
`else
        ptr = 0;
`endif
        cur_abc[w] = 3'($urandom_range(0, 7));
      end
    end else if (age >= 1 && rr) begin
      pending = 1'b0;
    end else begin
      age++;
    end
  endtask

  // Monitor: compares every presented result with the scoreboard head, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rsp_unexpected actual=id%0d expected=no_response at %0t", rsp_id, $time);
        end else begin
          checkVal("rsp_id", int'(rsp_id), sb[0].id);
          checkVal("rsp_y", int'(rsp_y), sb[0].y);
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) cur_abc[i] = 3'($urandom_range(0, 7));

    $display("[TB] reset with all requests high");
    repeat (2) begin
      applyStimulus(1'b1, 4'b1111, 1'b0);
      checkVal("rst_rsp_id", int'(rsp_id), 0);
      checkVal("rst_rsp_y", int'(rsp_y), 0);
    end

    $display("[TB] single request from requester 2");
    cur_abc[2] = 3'b011;
    applyStimulus(1'b0, 4'b0100, 1'b1);
    repeat (3) applyStimulus(1'b0, 4'b0000, 1'b1);
    cur_abc[2] = 3'b010;
    applyStimulus(1'b0, 4'b0100, 1'b1);
    repeat (3) applyStimulus(1'b0, 4'b0000, 1'b1);

    $display("[TB] truth table via requester 1");
    for (int v = 0; v < 8; v++) begin
      cur_abc[1] = 3'(v);
      applyStimulus(1'b0, 4'b0010, 1'b1);
      repeat (2) applyStimulus(1'b0, 4'b0000, 1'b1);
    end

    $display("[TB] contention, 12 results");
    repeat (36) applyStimulus(1'b0, 4'b1111, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 4'b1000, 1'b0);
    repeat (6) applyStimulus(1'b0, 4'b1111, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    repeat (4) applyStimulus(1'b0, 4'b0000, 1'b1);

    $display("[TB] randomized traffic");
    repeat (300) applyStimulus(1'b0, N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    repeat (4) applyStimulus(1'b0, 4'b0000, 1'b1);

    $display("[TB] reset while in RESP");
    applyStimulus(1'b0, 4'b0010, 1'b0);
    repeat (2) applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    repeat (3) applyStimulus(1'b0, 4'b0000, 1'b1);

    checkVal("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
